// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : EX-stage sequencer for the multi-cycle HI/LO unit. Runs
//               MULT/MULTU/MADD/MADDU/MSUB/MSUBU through a multiplier with
//               MUL_CYCLES latency and DIV/DIVU through an iterative radix-2
//               restoring divider. It holds the pipeline via stall_req and
//               writes the 64-bit result to HI/LO in a single cycle.
//
//               Optional feature macro: MULDIV_EARLY_TERM_EN
//                 defined   : a divide with |op_a| < |op_b| skips the
//                             iterations (quotient 0, remainder op_a).
//                 undefined : every divide runs all DATA_W iterations.
//
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active low
//               start      - EX holds a valid instruction this cycle
//               funct[5:0] - decoded funct code (SPECIAL2 ops remapped)
//               op_a       - rs (dividend / multiplicand)
//               op_b       - rt (divisor / multiplier)
//               hi_in      - current HI (accumulate source)
//               lo_in      - current LO (accumulate source)
//               flush      - cancel the in-flight operation
//               stall_req  - hold IF..EX
//               done       - one-cycle completion pulse
//               hilo_we    - write hi_out/lo_out into HI/LO
//               hi_out     - result high word (divide: remainder)
//               lo_out     - result low word  (divide: quotient)
//
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              flush,
    output logic              stall_req,
    output logic              done,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CNT_W = $clog2(DATA_W + MUL_CYCLES + 1);

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_MUL  = 3'd1;
    localparam logic [2:0] C_ACC  = 3'd2;
    localparam logic [2:0] C_DIV  = 3'd3;
    localparam logic [2:0] C_FIX  = 3'd4;
    localparam logic [2:0] C_DONE = 3'd5;

    // SPECIAL codes, plus SPECIAL2 MADD/MSUB family remapped by the ID stage
    // onto the unused SPECIAL slots 0x1C..0x1F.
    localparam logic [5:0] C_FN_MULT  = 6'h18;
    localparam logic [5:0] C_FN_MULTU = 6'h19;
    localparam logic [5:0] C_FN_DIV   = 6'h1A;
    localparam logic [5:0] C_FN_DIVU  = 6'h1B;
    localparam logic [5:0] C_FN_MADD  = 6'h1C;
    localparam logic [5:0] C_FN_MADDU = 6'h1D;
    localparam logic [5:0] C_FN_MSUB  = 6'h1E;
    localparam logic [5:0] C_FN_MSUBU = 6'h1F;

    // MUL occupies MUL_CYCLES-1 cycles; DIV occupies DATA_W cycles.
    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DATA_W - 1);

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     mul_a_q, mul_a_d;
    logic [DATA_W:0]     mul_b_q, mul_b_d;
    logic [2*DATA_W-1:0] hilo_acc_q, hilo_acc_d;
    logic                acc_q, acc_d;
    logic                sub_q, sub_d;
    logic                div0_q, div0_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                w_known, w_div, w_acc, w_sub, w_sgn;
    logic                w_a_neg, w_b_neg, w_early;
    logic [DATA_W:0]     w_a_ext, w_b_ext, w_mul_a, w_mul_b;
    logic [DATA_W-1:0]   w_a_mag, w_b_mag;
    logic [2*DATA_W-1:0] w_prod, w_acc_res;
    logic [DATA_W:0]     w_rem_sh;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem_sub;
    logic                w_busy;

    always_comb begin
        w_known = 1'b1;
        w_div   = 1'b0;
        w_acc   = 1'b0;
        w_sub   = 1'b0;
        w_sgn   = 1'b0;
        case (funct)
            C_FN_MULT:  w_sgn = 1'b1;
            C_FN_MULTU: w_sgn = 1'b0;
            C_FN_DIV:   begin w_div = 1'b1; w_sgn = 1'b1; end
            C_FN_DIVU:  w_div = 1'b1;
            C_FN_MADD:  begin w_acc = 1'b1; w_sgn = 1'b1; end
            C_FN_MADDU: w_acc = 1'b1;
            C_FN_MSUB:  begin w_acc = 1'b1; w_sub = 1'b1; w_sgn = 1'b1; end
            C_FN_MSUBU: begin w_acc = 1'b1; w_sub = 1'b1; end
            default:    w_known = 1'b0;
        endcase
    end

    // One extra sign/zero bit lets a single signed multiplier serve both flavours.
    assign w_a_neg = w_sgn & op_a[DATA_W-1];
    assign w_b_neg = w_sgn & op_b[DATA_W-1];
    assign w_a_ext = {w_a_neg, op_a};
    assign w_b_ext = {w_b_neg, op_b};
    assign w_a_mag = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag = w_b_neg ? (~op_b + 1'b1) : op_b;

`ifdef MULDIV_EARLY_TERM_EN
    assign w_early = (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // In IDLE the multiplier sees the ports so MUL_CYCLES==1 can finish at T+1.
    assign w_mul_a = (state_q == C_IDLE) ? w_a_ext : mul_a_q;
    assign w_mul_b = (state_q == C_IDLE) ? w_b_ext : mul_b_q;
    assign w_prod  = {{(DATA_W-1){w_mul_a[DATA_W]}}, w_mul_a}
                   * {{(DATA_W-1){w_mul_b[DATA_W]}}, w_mul_b};
    assign w_acc_res = sub_q ? (hilo_acc_q - w_prod) : (hilo_acc_q + w_prod);

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh  = {rem_q, quot_q[DATA_W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, dvs_q});
    assign w_rem_sub = w_rem_sh[DATA_W-1:0] - dvs_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        hilo_acc_d = hilo_acc_q;
        acc_d      = acc_q;
        sub_d      = sub_q;
        div0_d     = div0_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (flush) begin
            state_d = C_IDLE;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (start && w_known) begin
                        mul_a_d    = w_a_ext;
                        mul_b_d    = w_b_ext;
                        hilo_acc_d = {hi_in, lo_in};
                        acc_d      = w_acc;
                        sub_d      = w_sub;
                        div0_d     = 1'b0;
                        if (w_div) begin
                            negq_d = w_a_neg ^ w_b_neg;
                            negr_d = w_a_neg;
                            dvs_d  = w_b_mag;
                            cnt_d  = C_DIV_LOAD;
                            if (op_b == '0) begin
                                div0_d  = 1'b1;
                                state_d = C_DONE;
                            end else if (w_early) begin
                                quot_d  = '0;
                                rem_d   = w_a_mag;
                                state_d = C_FIX;
                            end else begin
                                quot_d  = w_a_mag;
                                rem_d   = '0;
                                state_d = C_DIV;
                            end
                        end else if (MUL_CYCLES > 1) begin
                            cnt_d   = C_MUL_LOAD;
                            state_d = C_MUL;
                        end else if (w_acc) begin
                            state_d = C_ACC;
                        end else begin
                            {hi_d, lo_d} = w_prod;
                            state_d      = C_DONE;
                        end
                    end
                end
                C_MUL: begin
                    if (cnt_q == '0) begin
                        if (acc_q) begin
                            state_d = C_ACC;
                        end else begin
                            {hi_d, lo_d} = w_prod;
                            state_d      = C_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                C_ACC: begin
                    {hi_d, lo_d} = w_acc_res;
                    state_d      = C_DONE;
                end
                C_DIV: begin
                    quot_d = {quot_q[DATA_W-2:0], w_ge};
                    rem_d  = w_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0];
                    if (cnt_q == '0) begin
                        state_d = C_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                C_FIX: begin
                    // Quotient sign from operand signs, remainder follows the dividend.
                    lo_d    = negq_q ? (~quot_q + 1'b1) : quot_q;
                    hi_d    = negr_q ? (~rem_q + 1'b1) : rem_q;
                    state_d = C_DONE;
                end
                C_DONE:  state_d = C_IDLE;
                default: state_d = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= C_IDLE;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            hilo_acc_q <= '0;
            acc_q      <= 1'b0;
            sub_q      <= 1'b0;
            div0_q     <= 1'b0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            hilo_acc_q <= hilo_acc_d;
            acc_q      <= acc_d;
            sub_q      <= sub_d;
            div0_q     <= div0_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign w_busy = (state_q == C_MUL) || (state_q == C_ACC)
                 || (state_q == C_DIV) || (state_q == C_FIX);

    // Stall is raised combinationally in the accept cycle so ID/IF hold at once.
    assign stall_req = !flush && (w_busy || ((state_q == C_IDLE) && start && w_known));
    assign done      = !flush && (state_q == C_DONE);
    assign hilo_we   = done && !div0_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl. The driver issues directed
//               and random operations and pushes the expected result and
//               latency computed by a plain-arithmetic reference model; a
//               monitor pops and compares whenever done is seen and checks
//               stall_req every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int W  = 32;
    localparam int MC = 2;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MADD  = 6'h1C;
    localparam logic [5:0] F_MADDU = 6'h1D;
    localparam logic [5:0] F_MSUB  = 6'h1E;
    localparam logic [5:0] F_MSUBU = 6'h1F;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [5:0]   funct = 6'h0;
    logic [W-1:0] op_a = '0, op_b = '0, hi_in = '0, lo_in = '0;
    logic         stall_req, done, hilo_we;
    logic [W-1:0] hi_out, lo_out;

    muldiv_ctrl #(.DATA_W(W), .MUL_CYCLES(MC)) u_dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .op_a(op_a), .op_b(op_b), .hi_in(hi_in), .lo_in(lo_in),
        .flush(flush), .stall_req(stall_req), .done(done),
        .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        int          lat;
        bit          we;
        logic [63:0] res;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Reference: results from ordinary 64-bit arithmetic, latency from the
    // published per-operation timing table.
    function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, b, h, l,
                                      output bit known, output bit we,
                                      output logic [63:0] r, output int lat);
        longint      sa, sbv, q, rm;
        logic [63:0] ua, ub, acc;
`ifdef MULDIV_EARLY_TERM_EN
        longint      ma, mb;
`endif
        known = 1'b1;
        we    = 1'b1;
        r     = '0;
        lat   = MC;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        ua    = {32'h0, a};
        ub    = {32'h0, b};
        acc   = {h, l};
        case (f)
            F_MULT:  r = sa * sbv;
            F_MULTU: r = ua * ub;
            F_MADD:  begin r = acc + 64'(sa * sbv); lat = MC + 1; end
            F_MADDU: begin r = acc + ua * ub;       lat = MC + 1; end
            F_MSUB:  begin r = acc - 64'(sa * sbv); lat = MC + 1; end
            F_MSUBU: begin r = acc - ua * ub;       lat = MC + 1; end
            F_DIV, F_DIVU: begin
                if (b == 32'h0) begin
                    we  = 1'b0;
                    lat = 1;
                end else begin
                    if (f == F_DIV) begin
                        q  = sa / sbv;
                        rm = sa % sbv;
                    end else begin
                        q  = longint'(ua / ub);
                        rm = longint'(ua % ub);
                    end
                    r   = {rm[31:0], q[31:0]};
                    lat = W + 2;
`ifdef MULDIV_EARLY_TERM_EN
                    ma = (f == F_DIV) ? ((sa < 0) ? -sa : sa) : longint'(ua);
                    mb = (f == F_DIV) ? ((sbv < 0) ? -sbv : sbv) : longint'(ub);
                    if (ma < mb) lat = 2;
`endif
                end
            end
            default: known = 1'b0;
        endcase
    endfunction

    // Monitor: stall window and completion checks, decoupled from the driver.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst) begin
            chk("stall_req", 64'(stall_req),
                64'((sb.size() > 0 && cyc < sb[0].t + sb[0].lat) ? 1 : 0));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_with_nothing_pending", 64'(done), 64'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("latency", 64'(cyc - m_e.t), 64'(m_e.lat));
                    chk("hilo_we", 64'(hilo_we), 64'(m_e.we));
                    if (m_e.we) chk("hi_lo", {hi_out, lo_out}, m_e.res);
                end
            end else begin
                chk("hilo_we_without_done", 64'(hilo_we), 64'd0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, b, h, l);
        exp_t e;
        bit   known;
        funct = f; op_a = a; op_b = b; hi_in = h; lo_in = l; start = 1'b1;
        ref_model(f, a, b, h, l, known, e.we, e.res, e.lat);
        e.t = cyc;
        if (known) sb.push_back(e);
        next_cycle();
        start = 1'b0;
    endtask

    // While busy, keep throwing starts at the DUT; they must be ignored.
    task automatic wait_idle();
        int n;
        logic [5:0] fns [8];
        fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MADD, F_MADDU, F_MSUB, F_MSUBU};
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            start = ($urandom_range(0, 1) == 1);
            funct = fns[$urandom_range(0, 7)];
            op_a  = $urandom(); op_b = $urandom();
            hi_in = $urandom(); lo_in = $urandom();
            next_cycle();
            n++;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            chk("completion_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_stall_req"}, 64'(stall_req), 64'd0);
        chk({nm, "_done"},      64'(done),      64'd0);
        chk({nm, "_hilo_we"},   64'(hilo_we),   64'd0);
        chk({nm, "_hi_lo"},     {hi_out, lo_out}, 64'd0);
    endtask

    initial begin
        logic [5:0] fns [8];
        fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MADD, F_MADDU, F_MSUB, F_MSUBU};

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();

        issue(F_MULT,  32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);          wait_idle();
        issue(F_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);          wait_idle();
        issue(F_DIV,   32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0);          wait_idle();
        issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);  wait_idle();
        issue(F_DIVU,  32'h1234_5678, 32'h0, 32'h0, 32'h0);          wait_idle();
        issue(F_DIVU,  32'h3, 32'hA, 32'h0, 32'h0);                  wait_idle();
        issue(F_MADD,  32'h3, 32'h4, 32'h0, 32'hFFFF_FFFF);          wait_idle();
        issue(F_MSUB,  32'h1, 32'h1, 32'h0, 32'h0);                  wait_idle();
        issue(6'h20,   32'h5, 32'h6, 32'h0, 32'h0);                  wait_idle();

        // Flush ten cycles into a divide, then a start the next cycle.
        issue(F_DIV, 32'd1000, 32'd7, 32'h0, 32'h0);
        repeat (9) next_cycle();
        flush = 1'b1;
        sb.delete();
        next_cycle();
        flush = 1'b0;
        issue(F_DIVU, 32'd1000, 32'd7, 32'h0, 32'h0);
        wait_idle();

        // Reset ten cycles into a divide.
        issue(F_DIV, 32'd1000, 32'd7, 32'h0, 32'h0);
        repeat (9) next_cycle();
        rst = 1'b0;
        sb.delete();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_op_reset");
        next_cycle();

        for (int i = 0; i < 60; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : fns[$urandom_range(0, 7)];
            issue(f, rand_opnd(), rand_opnd(), $urandom(), $urandom());
            wait_idle();
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        repeat (3) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
